store_buffer: RTL and testbench



---
 rtl/mips_mem_pkg.sv | 16 +
 rtl/sb_fwd_match.sv | 43 ++++
 rtl/store_buffer.sv | 114 +++++++++++
 tb/tb_store_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the memory-stage store buffer.
package mips_mem_pkg;

  localparam int unsigned LANES = 4;

  typedef struct packed {
    logic        valid;
    logic [29:0] waddr;
    logic [31:0] data;
  } sb_entry_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Store-to-load forwarding search for one load lane: youngest older-lane
// bundle store first, then youngest buffered entry.
module sb_fwd_match
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  sb_entry_t [DEPTH-1:0]        entries,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [LANES-1:0]             st_valid,
  input  logic [30*LANES-1:0]          st_waddr,
  input  logic [32*LANES-1:0]          st_data,
  input  logic [29:0]                  ld_waddr,
  output logic                         hit,
  output logic [31:0]                  data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Later matches overwrite earlier ones, so scanning oldest-to-youngest
  // and then the bundle leaves the highest-priority match standing.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (entries[idx].valid && (entries[idx].waddr == ld_waddr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
    for (int unsigned j = 0; j < LANES; j++) begin
      if (st_valid[j] && (st_waddr[30*j +: 30] == ld_waddr)) begin
        hit  = 1'b1;
        data = st_data[32*j +: 32];
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Four-in / two-out circular store buffer feeding a dual-write, quad-read
// data memory, with store-to-load forwarding on the read lanes.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LANES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [LANES-1:0]      st_valid,
  input  logic [32*LANES-1:0]   st_addr,
  input  logic [32*LANES-1:0]   st_data,
  output logic                  st_ready,
  input  logic                  drain_en,
  input  logic [32*LANES-1:0]   ld_addr,
  output logic [32*LANES-1:0]   ld_data,
  output logic                  mem_we,
  output logic                  mem_we2,
  output logic [31:0]           mem_wa1,
  output logic [31:0]           mem_wa2,
  output logic [31:0]           mem_wd1,
  output logic [31:0]           mem_wd2,
  output logic [32*LANES-1:0]   mem_ra,
  input  logic [32*LANES-1:0]   mem_rd,
  output logic                  empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 4);

  sb_entry_t [DEPTH-1:0]  entries;
  logic [PW-1:0]          head, tail, head1, off;
  logic [CW-1:0]          count;
  logic [LANES-1:0]       acc;
  logic [2:0]             n_in;
  logic [1:0]             n_out;
  logic [PW-1:0]          wr_idx [LANES];
  logic [30*LANES-1:0]    st_waddr;
  logic [2*LANES-1:0]     addr_lsbs;
  logic                   unused_addr_lsbs;

  assign st_ready = (count <= READY_MAX);
  assign acc      = st_ready ? st_valid : '0;
  assign n_in     = popcount4(acc);
  assign mem_we   = drain_en && (count != '0);
  assign mem_we2  = drain_en && (count >= CW'(2));
  assign n_out    = {1'b0, mem_we} + {1'b0, mem_we2};
  assign head1    = head + PW'(1);
  assign mem_wa1  = {entries[head].waddr, 2'b00};
  assign mem_wd1  = entries[head].data;
  assign mem_wa2  = {entries[head1].waddr, 2'b00};
  assign mem_wd2  = entries[head1].data;
  assign mem_ra   = ld_addr;
  assign empty    = (count == '0);

  always_comb begin
    off = '0;
    for (int unsigned j = 0; j < LANES; j++) begin
      st_waddr[30*j +: 30] = st_addr[32*j+2 +: 30];
      addr_lsbs[2*j +: 2]  = st_addr[32*j +: 2];
      wr_idx[j] = tail + off;
      if (acc[j]) off = off + PW'(1);
    end
  end
  assign unused_addr_lsbs = ^addr_lsbs;

  // Enqueue slots never overlap draining slots: acceptance needs four free
  // entries, so tail..tail+n_in-1 lies outside head..head+count-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entries <= '0;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
    end else begin
      if (mem_we)  entries[head].valid  <= 1'b0;
      if (mem_we2) entries[head1].valid <= 1'b0;
      for (int unsigned j = 0; j < LANES; j++) begin
        if (acc[j]) begin
          entries[wr_idx[j]] <= '{valid: 1'b1,
                                  waddr: st_waddr[30*j +: 30],
                                  data:  st_data[32*j +: 32]};
        end
      end
      head  <= head + PW'(n_out);
      tail  <= tail + PW'(n_in);
      count <= count + CW'(n_in) - CW'(n_out);
    end
  end

  assert property (@(posedge clk) disable iff (!reset_n) count <= CW'(DEPTH));

  for (genvar i = 0; i < LANES; i++) begin : g_ld
    localparam logic [LANES-1:0] OLDER = LANES'((1 << i) - 1);
    logic        hit;
    logic [31:0] fdata;

    sb_fwd_match #(.DEPTH(DEPTH)) u_fwd (
      .entries  (entries),
      .head     (head),
      .st_valid (acc & OLDER),
      .st_waddr (st_waddr),
      .st_data  (st_data),
      .ld_waddr (ld_addr[32*i+2 +: 30]),
      .hit      (hit),
      .data     (fdata)
    );

    assign ld_data[32*i +: 32] = hit ? fdata : mem_rd[32*i +: 32];
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: drain order, same-address pairs, full
// back-pressure, forwarding priority, misses and asynchronous reset.
module tb_store_buffer;

  logic         clk, reset_n;
  logic [3:0]   st_valid;
  logic [127:0] st_addr, st_data, ld_addr, ld_data, mem_ra, mem_rd;
  logic         st_ready, drain_en, mem_we, mem_we2, empty;
  logic [31:0]  mem_wa1, mem_wa2, mem_wd1, mem_wd2;

  int checks = 0;
  int errors = 0;

  store_buffer #(.DEPTH(8), .LANES(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .drain_en (drain_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .mem_we   (mem_we),
    .mem_we2  (mem_we2),
    .mem_wa1  (mem_wa1),
    .mem_wa2  (mem_wa2),
    .mem_wd1  (mem_wd1),
    .mem_wd2  (mem_wd2),
    .mem_ra   (mem_ra),
    .mem_rd   (mem_rd),
    .empty    (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_st(input int l, input logic [31:0] a, input logic [31:0] d);
    st_addr[32*l +: 32] = a;
    st_data[32*l +: 32] = d;
  endtask

  task automatic set_ld(input int l, input logic [31:0] a);
    ld_addr[32*l +: 32] = a;
  endtask

  function automatic logic [31:0] ldl(input int l);
    return ld_data[32*l +: 32];
  endfunction

  task automatic chk_drain(input string tag,
                           input logic [31:0] wa1, input logic [31:0] wd1,
                           input logic [31:0] wa2, input logic [31:0] wd2);
    chk({tag, "_we1"}, {31'b0, mem_we}, 32'd1);
    chk({tag, "_wa1"}, mem_wa1, wa1);
    chk({tag, "_wd1"}, mem_wd1, wd1);
    chk({tag, "_we2"}, {31'b0, mem_we2}, 32'd1);
    chk({tag, "_wa2"}, mem_wa2, wa2);
    chk({tag, "_wd2"}, mem_wd2, wd2);
  endtask

  initial begin
    reset_n  = 1'b1;
    st_valid = '0;
    st_addr  = '0;
    st_data  = '0;
    ld_addr  = '0;
    mem_rd   = '0;
    drain_en = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_ready", {31'b0, st_ready}, 32'd1);
    chk("rst_we", {30'b0, mem_we, mem_we2}, 32'd0);
    tick();
    reset_n = 1'b1;

    // Bundle of four, drained two per cycle.
    set_st(0, 32'h0, 32'd1); set_st(1, 32'h4, 32'd2);
    set_st(2, 32'h8, 32'd3); set_st(3, 32'hC, 32'd4);
    st_valid = 4'hF;
    drain_en = 1'b1;
    #1 chk("b1_pre_we", {31'b0, mem_we}, 32'd0);
    tick();
    st_valid = '0;
    #1;
    chk("b1_empty", {31'b0, empty}, 32'd0);
    chk("b1_ready", {31'b0, st_ready}, 32'd1);
    chk_drain("b1_d0", 32'h0, 32'd1, 32'h4, 32'd2);
    tick();
    chk_drain("b1_d1", 32'h8, 32'd3, 32'hC, 32'd4);
    tick();
    chk("b1_done_empty", {31'b0, empty}, 32'd1);
    chk("b1_done_we", {30'b0, mem_we, mem_we2}, 32'd0);

    // Same-address pair: younger store rides port 2.
    set_st(0, 32'h10, 32'hA); set_st(1, 32'h10, 32'hB);
    st_valid = 4'b0011;
    set_ld(2, 32'h10);
    #1 chk("sa_fwd_bundle", ldl(2), 32'hB);
    tick();
    st_valid = '0;
    #1;
    chk_drain("sa_d", 32'h10, 32'hA, 32'h10, 32'hB);
    chk("sa_fwd_buf", ldl(2), 32'hB);
    tick();
    chk("sa_empty", {31'b0, empty}, 32'd1);

    // Fill to DEPTH with drain off; third bundle must be ignored.
    drain_en = 1'b0;
    for (int l = 0; l < 4; l++) set_st(l, 32'h100 + 32'(4*l), 32'h11 + 32'(l));
    st_valid = 4'hF;
    tick();
    for (int l = 0; l < 4; l++) set_st(l, 32'h110 + 32'(4*l), 32'h21 + 32'(l));
    #1;
    chk("full_ready4", {31'b0, st_ready}, 32'd1);
    chk("full_nowe", {31'b0, mem_we}, 32'd0);
    tick();
    for (int l = 0; l < 4; l++) set_st(l, 32'h200 + 32'(4*l), 32'h99);
    set_ld(1, 32'h200);
    mem_rd[63:32] = 32'h5555;
    #1;
    chk("full_ready8", {31'b0, st_ready}, 32'd0);
    chk("full_nofwd", ldl(1), 32'h5555);
    tick();
    chk("full_hold_ready", {31'b0, st_ready}, 32'd0);
    chk("full_hold_empty", {31'b0, empty}, 32'd0);
    st_valid = '0;
    drain_en = 1'b1;
    #1 chk_drain("full_d0", 32'h100, 32'h11, 32'h104, 32'h12);
    tick();
    chk("full_ready6", {31'b0, st_ready}, 32'd0);
    chk_drain("full_d1", 32'h108, 32'h13, 32'h10C, 32'h14);
    tick();
    chk("full_ready_again", {31'b0, st_ready}, 32'd1);
    chk_drain("full_d2", 32'h110, 32'h21, 32'h114, 32'h22);
    tick();
    chk_drain("full_d3", 32'h118, 32'h23, 32'h11C, 32'h24);
    tick();
    chk("full_drained", {31'b0, empty}, 32'd1);

    // Forwarding priority and misses.
    drain_en = 1'b0;
    mem_rd   = {4{32'hDEAD}};
    set_st(0, 32'h20, 32'd5); set_st(1, 32'h20, 32'd7);
    st_valid = 4'b0011;
    tick();
    st_valid = '0;
    set_ld(2, 32'h20); set_ld(3, 32'h40);
    #1;
    chk("fw_buf_young", ldl(2), 32'd7);
    chk("fw_miss", ldl(3), 32'hDEAD);
    chk("fw_mem_ra", mem_ra[95:64], 32'h20);
    set_st(0, 32'h20, 32'd9); set_st(3, 32'h40, 32'h77);
    st_valid = 4'b1001;
    set_ld(0, 32'h20); set_ld(1, 32'h23);
    #1;
    chk("fw_own_lane", ldl(0), 32'd7);
    chk("fw_lsb_ignored", ldl(1), 32'd9);
    chk("fw_bundle", ldl(2), 32'd9);
    chk("fw_younger_lane", ldl(3), 32'hDEAD);
    tick();
    set_st(0, 32'h30, 32'h30);
    st_valid = 4'b0001;
    #1 chk("fw_buf_lane3", ldl(3), 32'h77);
    tick();

    // Reset with five buffered stores while draining.
    st_valid = '0;
    drain_en = 1'b1;
    #1 chk_drain("rm_pre", 32'h20, 32'd5, 32'h20, 32'd7);
    reset_n = 1'b0;
    #1;
    chk("rm_we", {30'b0, mem_we, mem_we2}, 32'd0);
    chk("rm_empty", {31'b0, empty}, 32'd1);
    chk("rm_ready", {31'b0, st_ready}, 32'd1);
    chk("rm_ld", ldl(2), 32'hDEAD);
    tick();
    reset_n = 1'b1;
    tick();
    chk("rm_after_we", {30'b0, mem_we, mem_we2}, 32'd0);
    chk("rm_after_empty", {31'b0, empty}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
